// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, issues one-cycle-latency
//   instruction-memory reads and buffers the returned {instr, pc} pairs in a
//   QDEPTH-entry FIFO. The FIFO head is presented to the decode stage with a
//   valid/ready handshake. A branch redirect from decode flushes every
//   wrong-path fetch and restarts fetching at the branch target.
//
//   Optional feature macro: IF_PERF_CNT_EN
//     defined   -> saturating 32-bit redirect and stall counters
//     undefined -> flush_cnt and stall_cnt are tied to zero, with no flops
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int          QDEPTH   = 4,      // power of two, >= 2
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction memory
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    // redirect from decode
    input  logic        br_taken,
    input  logic [63:0] br_target,
    // handshake to decode
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    // performance counters
    output logic [31:0] flush_cnt,
    output logic [31:0] stall_cnt
);

    localparam int PW = $clog2(QDEPTH);   // pointer width
    localparam int CW = PW + 1;           // occupancy width, holds 0..QDEPTH

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]    r_pc;
    logic [63:0]    r_pc_inflight;
    logic           r_inflight;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;

    logic [31:0]    r_q_instr [QDEPTH];
    logic [63:0]    r_q_pc    [QDEPTH];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [CW:0]    w_occupancy;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;

    // The queue plus the outstanding read must never exceed QDEPTH. Counting the
    // in-flight slot as a credit means a response always has room when it arrives.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

    // The reset_n term forces imem_req low while reset is held.
    // A redirect in the current cycle suppresses the wrong-path fetch.
    assign w_issue     = reset_n && !br_taken && (w_occupancy < (CW+1)'(QDEPTH));

    assign w_valid     = (r_count != '0);

    // A redirect cancels both the response arriving this cycle and any pop.
    assign w_push      = r_inflight && !br_taken;
    assign w_pop       = w_valid && id_ready && !br_taken;

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;

    assign if_valid    = w_valid;
    assign if_instr    = w_valid ? r_q_instr[r_head] : 32'd0;
    assign if_pc       = w_valid ? r_q_pc[r_head]    : 64'd0;

    // ------------------------------------------------------------------
    // PC and in-flight request tracking
    // ------------------------------------------------------------------
    // Advance the PC on each issue and load the target on a redirect.
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_pc_inflight <= 64'd0;
            r_inflight    <= 1'b0;
        end else begin
            if (br_taken) begin
                r_pc <= br_target;
            end else if (w_issue) begin
                r_pc <= r_pc + 64'd4;       // wraps modulo 2^64
            end

            if (w_issue) begin
                r_pc_inflight <= r_pc;
            end

            // w_issue is already low during a redirect, so a flush clears this.
            r_inflight <= w_issue;
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    // Move the FIFO pointers and the occupancy count; a redirect empties the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (br_taken) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);  // power-of-two depth wraps naturally
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // Write each returning instruction and its PC into the tail slot.
    // NOTE: the storage array is deliberately left out of reset. Occupancy
    // lives in r_count, and the outputs are zeroed whenever the queue is
    // empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pc[r_tail]    <= r_pc_inflight;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_stall_cnt;

    // Count redirects and back-pressure cycles, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (br_taken && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (w_valid && !id_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign flush_cnt = r_flush_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign flush_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule
